// File: rtl/keccak_masked_host_if.sv
// Host/core signal bundle for keccak_masked_host.
//   slave  : the host block's view (drives ready, shares, core reset, result).
//   master : the environment's view (drives plain input, randomness, core
//            response and the output consumer handshake).
// Signals:
//   plain_in/plain_valid/plain_ready   unmasked input handshake
//   mask_rand                          d*W bits of fresh randomness
//   core_in/core_reset                 shares and active-high reset to the core
//   core_ready/core_out                core completion flag and output shares
//   plain_out/out_valid/out_ready      unmasked result handshake
//   busy/error/cycles                  status
interface keccak_masked_host_if #(
  parameter int d = 2,
  parameter int W = 200
);
  logic [W-1:0]         plain_in;
  logic                 plain_valid;
  logic                 plain_ready;
  logic [d*W-1:0]       mask_rand;
  logic [(d+1)*W-1:0]   core_in;
  logic                 core_reset;
  logic                 core_ready;
  logic [(d+1)*W-1:0]   core_out;
  logic [W-1:0]         plain_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 error;
  logic [7:0]           cycles;

  modport slave (
    input  plain_in, plain_valid, mask_rand, core_ready, core_out, out_ready,
    output plain_ready, core_in, core_reset, plain_out, out_valid, busy, error, cycles
  );

  modport master (
    output plain_in, plain_valid, mask_rand, core_ready, core_out, out_ready,
    input  plain_ready, core_in, core_reset, plain_out, out_valid, busy, error, cycles
  );
endinterface

// File: rtl/keccak_masked_host.sv
// Host-side driver for a masked Keccak-f[200] core at protection order d.
// Takes one unmasked W-bit state, splits it into d+1 Boolean shares using
// caller randomness, walks the core through its reset/Ready protocol, then
// recombines the output shares into an unmasked registered result.
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous, active-low
//   bus    keccak_masked_host_if.slave (see interface header)
// Share packing on core_in/core_out is {share d, ..., share 0}, share i at
// [i*W +: W]. Shares 0..d-1 are the mask slices; share d = plain ^ masks.
// The state is processed as NUM_LANES lanes of VEC_W bits (W % VEC_W == 0).

// One VEC_W-bit lane: builds the top share and recombines output shares.
module keccak_masked_lane #(
  parameter int d     = 2,
  parameter int VEC_W = 8
)(
  input  logic [VEC_W-1:0]          plain,
  input  logic [d-1:0][VEC_W-1:0]   mask,
  input  logic [d:0][VEC_W-1:0]     shares,
  output logic [VEC_W-1:0]          top,
  output logic [VEC_W-1:0]          recomb
);
  always_comb begin
    top = plain;
    for (int j = 0; j < d; j++) top = top ^ mask[j];
    recomb = '0;
    for (int j = 0; j <= d; j++) recomb = recomb ^ shares[j];
  end
endmodule

module keccak_masked_host #(
  parameter int d        = 2,
  parameter int W        = 200,
  parameter int LOAD_CYC = 2,
  parameter int TIMEOUT  = 64,
  parameter int VEC_W    = 8
)(
  input  logic                  clock,
  input  logic                  reset,
  keccak_masked_host_if.slave   bus
);
  localparam int NUM_LANES = W / VEC_W;
  localparam int LW        = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  logic                 accept;
  logic                 rise;
  logic                 run_to;
  logic                 load_end;
  logic [LW-1:0]        lcnt;
  logic [7:0]           rcnt;
  logic                 rdy_q;
  logic [(d+1)*W-1:0]   core_in_q;
  logic [W-1:0]         plain_out_q;
  logic                 error_q;
  logic [7:0]           cycles_q;

  logic [NUM_LANES-1:0][VEC_W-1:0]          pin_l;
  logic [NUM_LANES-1:0][VEC_W-1:0]          top_l;
  logic [NUM_LANES-1:0][VEC_W-1:0]          rec_l;
  logic [NUM_LANES-1:0][d-1:0][VEC_W-1:0]   msk_l;
  logic [NUM_LANES-1:0][d:0][VEC_W-1:0]     sh_l;
  logic [(d+1)*W-1:0]                       shares_nxt;
  logic [W-1:0]                             recomb;

  // Lane gather/scatter: share j of lane i lives at [j*W + i*VEC_W +: VEC_W].
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign pin_l[i] = bus.plain_in[i*VEC_W +: VEC_W];
    for (genvar j = 0; j < d; j++) begin : g_msk
      assign msk_l[i][j] = bus.mask_rand[j*W + i*VEC_W +: VEC_W];
      assign shares_nxt[j*W + i*VEC_W +: VEC_W] = msk_l[i][j];
    end
    for (genvar j = 0; j <= d; j++) begin : g_sh
      assign sh_l[i][j] = bus.core_out[j*W + i*VEC_W +: VEC_W];
    end
    assign shares_nxt[d*W + i*VEC_W +: VEC_W] = top_l[i];
    assign recomb[i*VEC_W +: VEC_W] = rec_l[i];

    keccak_masked_lane #(.d(d), .VEC_W(VEC_W)) u_lane (
      .plain  (pin_l[i]),
      .mask   (msk_l[i]),
      .shares (sh_l[i]),
      .top    (top_l[i]),
      .recomb (rec_l[i])
    );
  end

  assign accept   = (state == S_IDLE) && reset && bus.plain_valid;
  assign load_end = (lcnt == '0);
  // rdy_q is cleared on RUN entry, so a Ready level left high by a stale
  // result would look like an edge in the first RUN cycle. A core cannot
  // finish in zero cycles, so that cycle only primes the detector.
  assign rise     = bus.core_ready && !rdy_q && (rcnt != '0);
  assign run_to   = !rise && (rcnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_LOAD;
      S_LOAD: if (load_end) state_nxt = S_RUN;
      S_RUN: begin
        if (rise)        state_nxt = S_DONE;
        else if (run_to) state_nxt = S_IDLE;
      end
      S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      core_in_q   <= '0;
      plain_out_q <= '0;
      error_q     <= 1'b0;
      cycles_q    <= '0;
      lcnt        <= '0;
      rcnt        <= '0;
      rdy_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            // mask_rand is consumed only here; shares are frozen until next accept
            core_in_q <= shares_nxt;
            error_q   <= 1'b0;
            cycles_q  <= '0;
            lcnt      <= LW'(LOAD_CYC - 1);
          end
        end
        S_LOAD: begin
          if (load_end) begin
            rdy_q <= 1'b0;
            rcnt  <= '0;
          end else begin
            lcnt <= lcnt - 1'b1;
          end
        end
        S_RUN: begin
          rdy_q <= bus.core_ready;
          if (rise) begin
            plain_out_q <= recomb;
          end else begin
            // Cycles counts the RUN cycles that elapse before Ready rises
            if (cycles_q != 8'hff) cycles_q <= cycles_q + 8'd1;
            rcnt <= rcnt + 8'd1;
            if (run_to) error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs are also gated by reset so they are inactive for the
  // whole time reset is asserted, not only after the first reset edge.
  assign bus.plain_ready = reset && (state == S_IDLE);
  assign bus.out_valid   = reset && (state == S_DONE);
  assign bus.core_reset  = !reset || (state != S_RUN);
  assign bus.busy        = (state != S_IDLE);
  assign bus.core_in     = core_in_q;
  assign bus.plain_out   = plain_out_q;
  assign bus.error       = error_q;
  assign bus.cycles      = cycles_q;
endmodule

// File: doc/keccak_masked_host.md
Name: keccak_masked_host

Overview:
- Host-side driver for the masked Keccak-f[200] core `keccak_top`, operating at protection order d.
- Accepts one unmasked 200-bit state per transaction on a valid/ready handshake.
- Splits the state into d+1 Boolean shares using caller-supplied randomness, then sequences the core's active-high reset/Ready protocol.
- Recombines the output shares and returns the unmasked 200-bit result on a second valid/ready handshake, with a watchdog for a core that never completes.

Parameters:
- d, 2, protection order; the core is driven with d+1 shares.
- W, 200, state width in bits.
- LOAD_CYC, 2, cycles CoreReset is held high with shares stable before release; minimum 1.
- TIMEOUT, 64, maximum cycles to wait for CoreReady after release; range 1..255.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- PlainIn  in  W  unmasked input state.
- PlainValid  in  1  PlainIn valid.
- PlainReady  out  1  block can accept an input.
- MaskRand  in  d*W  fresh randomness; sampled only on the accept cycle.
- CoreIn  out  (d+1)*W  to core InData; slices [i*W +: W] = MaskRand[i*W +: W] for i=0..d-1; top slice = PlainIn XOR all d MaskRand slices.
- CoreReset  out  1  to core Reset, active-high.
- CoreReady  in  1  core Ready.
- CoreOut  in  (d+1)*W  core OutData shares.
- PlainOut  out  W  unmasked result, XOR of all d+1 CoreOut slices, registered.
- OutValid  out  1  PlainOut valid.
- OutReady  in  1  consumer accepts PlainOut.
- Busy  out  1  high in LOAD, RUN and DONE.
- Error  out  1  sticky timeout flag; cleared on the next accept.
- Cycles  out  8  cycles counted from core release to CoreReady rise, saturating at 255.

Behaviour:
Reset (Reset=0 at a clock edge):
- State goes to IDLE.
- CoreReset=1, PlainReady=0, OutValid=0, Busy=0, Error=0, Cycles=0, PlainOut=0, CoreIn=0.
- Applies mid-transaction as well: any in-flight result is discarded and the core stays held in reset.

IDLE:
- PlainReady=1 and CoreReset=1.
- Accept when PlainValid=1 and PlainReady=1.
- On accept: register the shares into CoreIn; clear Error; clear Cycles; load the counter; go to LOAD.

LOAD:
- CoreReset=1 and CoreIn held stable for exactly LOAD_CYC cycles, then go to RUN.

RUN:
- CoreReset=0 and CoreIn held stable.
- Keep a 1-cycle delayed copy of CoreReady.
- Completion is a rising edge only: CoreReady=1 and previous=0. A level that is already high from a stale previous result is ignored.
- The edge detector's previous value is forced to 0 on entry to RUN.
- Cycles increments each RUN cycle.
- On a rising edge: PlainOut <= XOR of the d+1 CoreOut slices (sampled that same cycle); go to DONE.
- After TIMEOUT RUN cycles with no edge: set Error=1, leave PlainOut unchanged, go to IDLE. The IDLE entry asserts CoreReset=1 and OutValid stays 0.

DONE:
- OutValid=1 with PlainOut held stable.
- CoreReset=1 is reasserted on entry, so the core does not run again.
- On OutValid=1 and OutReady=1: OutValid drops on the next cycle and the state goes to IDLE.
- Back-to-back transactions: PlainReady rises in the cycle after the output handshake. There is no overlap; at most one transaction is in flight.

Other rules:
- PlainValid while not in IDLE: ignored, PlainReady=0, and the input must be held by the source.
- The CoreIn share layout matches the core's {share d, ..., share 0} packing.
- Unmasked data exists only at PlainIn and PlainOut.
- MaskRand is never reused: it is sampled only on the accept edge.
- Busy = (state != IDLE).

Test Plan:
- Reset=0 for 5 cycles → CoreReset=1, PlainReady=0, OutValid=0, Error=0 every cycle; after release PlainReady=1.
- With the real core, PlainIn = {128'hff..ff, 72'h0123456789abcdef01} and random MaskRand → PlainOut = 200'he090c8c5e596d3421d2fcc695838626cbb365352811837480f with OutValid=1. Repeating with new MaskRand gives the same PlainOut, while the CoreIn shares differ.
- Behavioural core model with Ready rising 10 cycles after release; PlainIn=0; MaskRand all ones → CoreIn top slice = XOR of the d ones-slices (d=2 gives 0), lower slices all ones; CoreReset high for exactly 2 cycles; Cycles=10.
- Model CoreReady stuck high from a previous run → no false completion. Never raise it afterwards → Error=1 after 64 RUN cycles, return to IDLE, OutValid never asserted, CoreReset=1; the next accept clears Error.
- OutReady held low for 20 cycles in DONE → OutValid and PlainOut stable, PlainReady=0, PlainValid ignored; OutReady=1 → next cycle OutValid=0, PlainReady=1.
- Reset=0 asserted mid-RUN → next edge IDLE, CoreReset=1, OutValid=0; a later CoreReady edge is ignored; a new transaction completes correctly.
